ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 159 +++++++++++++++
 tb/tb_ram_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-clock word RAM with a CPU port (A) and a secondary read
// port (B) for a loader or video fetcher. Port A has strict priority; port B
// is served only in cycles where A is idle. The top window WP_BASE..DEPTH-1
// can be write-protected with wp. Addresses at or above DEPTH read as 0 and
// ignore writes.
//
// Optional feature: define RAM_CTRL_CLEAR_EN to build the post-reset clear
// sweep, which writes FILL to every word before normal operation starts.
// Without the macro, the block comes out of reset directly in normal
// operation, busy is tied low, and the contents start uninitialised.
module ram_ctrl #(
   parameter int                DATA_W  = 8,
   parameter int                ADDR_W  = 16,
   parameter int                DEPTH   = 49152,
   parameter int                WP_BASE = 32768,
   parameter logic [DATA_W-1:0] FILL    = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] address,
   input  logic              w_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   input  logic              wp,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_dout,
   output logic              busy
);

   // Array index width; range checks guard every access, so the index may
   // span more words than are implemented when DEPTH is not a power of two.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] WP_C    = (ADDR_W+1)'(WP_BASE);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] dout_q, dout_d;
   logic [DATA_W-1:0] b_dout_q, b_dout_d;
   logic              b_ack_q, b_ack_d;

   logic              sweep;
   logic [IDX_W-1:0]  clr_idx;

   logic [ADDR_W-1:0] rd_addr;
   logic              rd_hit;
   logic [DATA_W-1:0] rd_word;
   logic              a_in_range;
   logic              a_wp_block;
   logic              a_wr_ok;
   logic              b_serve;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_wa;
   logic [DATA_W-1:0] mem_wd;

`ifdef RAM_CTRL_CLEAR_EN
   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             busy_q, busy_d;

   // Sweep sequencing: advance one word per cycle, leave CLEAR after the last word.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      if (state_q == CLEAR) begin
         if (clr_cnt_q == LAST_IDX) begin
            state_d   = RUN;
            clr_cnt_d = '0;
            busy_d    = 1'b0;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end
   end

   // Sweep FSM registers; reset always restarts the sweep from word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign sweep   = busy_q;
   assign clr_idx = clr_cnt_q;
`else
   assign sweep   = 1'b0;
   assign clr_idx = '0;
`endif

   assign busy = sweep;

   // Access arbitration, range/protect decode and the shared read mux.
   always_comb begin
      a_in_range = ({1'b0, address} < DEPTH_C);
      a_wp_block = wp & ({1'b0, address} >= WP_C);
      a_wr_ok    = a_en & w_en & a_in_range & ~a_wp_block & ~sweep;
      b_serve    = b_req & ~a_en & ~sweep & ~b_ack_q;
      rd_addr    = a_en ? address : b_addr;
      rd_hit     = ({1'b0, rd_addr} < DEPTH_C);
      rd_word    = rd_hit ? mem[rd_addr[IDX_W-1:0]] : '0;
      mem_we     = ~reset & (sweep | a_wr_ok);
      mem_wa     = sweep ? clr_idx : address[IDX_W-1:0];
      mem_wd     = sweep ? FILL : din;
   end

   // Next values of the read outputs: A holds when idle, B holds between acks.
   always_comb begin
      dout_d   = dout_q;
      b_dout_d = b_dout_q;
      b_ack_d  = b_serve;
      if (sweep) begin
         dout_d = '0;
      end else if (a_en) begin
         dout_d = rd_word;
      end
      if (b_serve) begin
         b_dout_d = rd_word;
      end
   end

   // Output registers; reset clears read data and drops any pending B service.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q   <= '0;
         b_dout_q <= '0;
         b_ack_q  <= 1'b0;
      end else begin
         dout_q   <= dout_d;
         b_dout_q <= b_dout_d;
         b_ack_q  <= b_ack_d;
      end
   end

   // Storage write port; no reset so contents survive reset except via the sweep.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   assign dout   = dout_q;
   assign b_dout = b_dout_q;
   assign b_ack  = b_ack_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed bench for ram_ctrl (DEPTH=32, WP_BASE=24, FILL=0xC3).
// Sweep-specific steps are built only when RAM_CTRL_CLEAR_EN is defined.
module tb_ram_ctrl;

   localparam int         DATA_W  = 8;
   localparam int         ADDR_W  = 16;
   localparam int         DEPTH   = 32;
   localparam int         WP_BASE = 24;
   localparam logic [7:0] FILL    = 8'hC3;

   logic              clk     = 1'b0;
   logic              reset   = 1'b1;
   logic              a_en    = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic              w_en    = 1'b0;
   logic [DATA_W-1:0] din     = '0;
   logic              wp      = 1'b0;
   logic              b_req   = 1'b0;
   logic [ADDR_W-1:0] b_addr  = '0;
   logic [DATA_W-1:0] dout;
   logic              b_ack;
   logic [DATA_W-1:0] b_dout;
   logic              busy;

   int n_assert = 0;
   int n_fail   = 0;

   ram_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .WP_BASE(WP_BASE),
      .FILL   (FILL)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .a_en   (a_en),
      .address(address),
      .w_en   (w_en),
      .din    (din),
      .dout   (dout),
      .wp     (wp),
      .b_req  (b_req),
      .b_addr (b_addr),
      .b_ack  (b_ack),
      .b_dout (b_dout),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int addr, input logic [7:0] data);
      a_en    = 1'b1;
      w_en    = 1'b1;
      address = ADDR_W'(addr);
      din     = data;
      tick();
      a_en = 1'b0;
      w_en = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int addr, input logic [7:0] exp);
      a_en    = 1'b1;
      w_en    = 1'b0;
      address = ADDR_W'(addr);
      tick();
      a_en = 1'b0;
      check(tag, 32'(dout), 32'(exp));
   endtask

   task automatic run_sweep(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
         check({tag, " dout during sweep"}, 32'(dout), 32'h0);
         check({tag, " b_ack during sweep"}, 32'(b_ack), 32'h0);
      end
      check({tag, " busy cycles"}, 32'(n), 32'(DEPTH));
   endtask

   initial begin
      // Reset state
      tick();
      check("reset dout", 32'(dout), 32'h0);
      check("reset b_ack", 32'(b_ack), 32'h0);
      check("reset b_dout", 32'(b_dout), 32'h0);
`ifdef RAM_CTRL_CLEAR_EN
      check("reset busy", 32'(busy), 32'h1);
      reset = 1'b0;
      // Port A writes during the sweep must be ignored
      a_en = 1'b1; w_en = 1'b1; address = 16'd3; din = 8'h11;
      run_sweep("sweep1");
      a_en = 1'b0; w_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) rd_chk("fill readback", i, FILL);
`else
      check("reset busy", 32'(busy), 32'h0);
      reset = 1'b0;
      tick();
      check("busy idle", 32'(busy), 32'h0);
`endif

      // Write then read, and read-old-data on same-cycle write/read
      wr(16, 8'hA5);
      rd_chk("read after write", 16, 8'hA5);
      a_en = 1'b1; w_en = 1'b1; address = 16'd16; din = 8'h5A;
      tick();
      a_en = 1'b0; w_en = 1'b0;
      check("same-cycle old data", 32'(dout), 32'hA5);
      rd_chk("new data visible", 16, 8'h5A);
      address = 16'd3;
      tick();
      check("dout hold a_en low", 32'(dout), 32'h5A);

      // Write protection of the top window
      wr(WP_BASE, 8'h33);
      wp = 1'b1;
      wr(WP_BASE, 8'h77);
      rd_chk("wp blocks write", WP_BASE, 8'h33);
      wr(WP_BASE - 1, 8'h44);
      rd_chk("wp below window", WP_BASE - 1, 8'h44);
      wp = 1'b0;
      wr(WP_BASE, 8'h77);
      rd_chk("wp off write", WP_BASE, 8'h77);

      // Port B stalled behind port A, then served on the first free cycle
      wr(9, 8'h99);
      b_req = 1'b1; b_addr = 16'd9;
      a_en = 1'b1; address = 16'd1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("b_ack while a_en", 32'(b_ack), 32'h0);
      end
      a_en = 1'b0;
      tick();
      check("b_ack after free", 32'(b_ack), 32'h1);
      check("b_dout after free", 32'(b_dout), 32'h99);
      b_req = 1'b0;
      tick();
      check("b_ack pulse ends", 32'(b_ack), 32'h0);
      check("b_dout held", 32'(b_dout), 32'h99);

      // Request withdrawn before service gives no ack
      a_en = 1'b1; b_req = 1'b1;
      tick();
      a_en = 1'b0; b_req = 1'b0;
      tick();
      check("dropped req 1", 32'(b_ack), 32'h0);
      tick();
      check("dropped req 2", 32'(b_ack), 32'h0);

      // Port B out of range reads 0
      b_req = 1'b1; b_addr = 16'd40;
      tick();
      b_req = 1'b0;
      check("b oob ack", 32'(b_ack), 32'h1);
      check("b oob data", 32'(b_dout), 32'h0);
      tick();

      // Back-to-back port B requests: one service per two cycles
      b_req = 1'b1; b_addr = 16'd16;
      tick();
      check("b2b ack 1", 32'(b_ack), 32'h1);
      check("b2b data 1", 32'(b_dout), 32'h5A);
      tick();
      check("b2b gap", 32'(b_ack), 32'h0);
      tick();
      check("b2b ack 2", 32'(b_ack), 32'h1);
      b_req = 1'b0;
      tick();
      check("b2b end", 32'(b_ack), 32'h0);

      // Port A out of range: write ignored (no alias onto word 0), read 0
      wr(0, 8'h12);
      wr(DEPTH, 8'hEE);
      rd_chk("oob read", DEPTH, 8'h00);
      rd_chk("oob no alias", 0, 8'h12);

`ifdef RAM_CTRL_CLEAR_EN
      // Reset part-way through a sweep restarts it at word 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1; b_req = 1'b1; b_addr = 16'd9;
      tick();
      check("mid reset busy", 32'(busy), 32'h1);
      check("mid reset dout", 32'(dout), 32'h0);
      check("mid reset b_ack", 32'(b_ack), 32'h0);
      check("mid reset b_dout", 32'(b_dout), 32'h0);
      reset = 1'b0;
      run_sweep("sweep2");
      b_req = 1'b0;
      rd_chk("resweep 0", 0, FILL);
      rd_chk("resweep 7", 7, FILL);
      rd_chk("resweep 16", 16, FILL);
      rd_chk("resweep wp", WP_BASE, FILL);
`else
      // Reset leaves contents intact and cancels port B service
      reset = 1'b1; b_req = 1'b1; b_addr = 16'd9;
      tick();
      check("reset2 busy", 32'(busy), 32'h0);
      check("reset2 dout", 32'(dout), 32'h0);
      check("reset2 b_ack", 32'(b_ack), 32'h0);
      check("reset2 b_dout", 32'(b_dout), 32'h0);
      reset = 1'b0; b_req = 1'b0;
      tick();
      rd_chk("retained 16", 16, 8'h5A);
      rd_chk("retained wp", WP_BASE, 8'h77);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
